alu_cmd_sequencer: RTL and testbench

//  Initiator side of the 16-bit ALU interface. Accepts operation commands (A, B, FUN) on a

---
 rtl/alu_cmd_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: initiator side of the ALU operand/function bus.
// Commands enter a small FIFO and are issued one at a time. Each ALU result is
// captured together with its class flags and returned on a valid/ready port.
// Optional feature: define ALU_SEQ_FLAGCHK_EN to compare the captured flags
// against the one-hot class implied by the function code and report the result
// on rsp_err. Without the macro, rsp_err is tied low and no check logic exists.
module alu_cmd_sequencer #(
    parameter int DATA_W  = 16,
    parameter int FUN_W   = 4,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [FUN_W-1:0]  cmd_fun,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [FUN_W-1:0]  alu_fun,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [3:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [FUN_W-1:0]  fun;
    } cmd_t;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             capture;
    logic             load_cnt;
    logic [CNT_W-1:0] wait_cnt;
    state_t           state;
    state_t           state_nxt;

    // Full exactly when the MSB of the count is set (DEPTH is a power of 2),
    // so readiness depends only on registered state, never on a same-cycle pop.
    assign cmd_ready  = ~count[PTR_W];
    assign fifo_empty = (count == '0);
    assign push       = cmd_valid & cmd_ready;
    assign busy       = ~fifo_empty | (state != IDLE);

    // Command storage: written on push, read at the head on pop.
    // NOTE: storage has no reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, fun: cmd_fun};
        end
    end

    // FIFO pointers wrap naturally at DEPTH; count tracks occupancy.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = (ALU_LAT == 0) ? HOLD : WAIT;
            WAIT:    if (wait_cnt == '0) state_nxt = HOLD;
            HOLD:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: pop/capture strobes and the response valid.
    always_comb begin
        pop       = (state == IDLE) && !fifo_empty;
        capture   = ((state == ISSUE) && (ALU_LAT == 0)) ||
                    ((state == WAIT) && (wait_cnt == '0));
        load_cnt  = (state == ISSUE) && (ALU_LAT != 0);
        rsp_valid = (state == HOLD);
    end

    // Wait counter covers the ALU pipeline latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (load_cnt) begin
            wait_cnt <= CNT_W'(ALU_LAT - 1);
        end else if ((state == WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Operand bus is loaded only when a command is popped and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_fun <= '0;
        end else if (pop) begin
            alu_a   <= mem[rd_ptr].a;
            alu_b   <= mem[rd_ptr].b;
            alu_fun <= mem[rd_ptr].fun;
        end
    end

    // Response registers capture the ALU result and stay stable through HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else if (capture) begin
            rsp_data  <= alu_out;
            rsp_flags <= alu_flags;
        end
    end

`ifdef ALU_SEQ_FLAGCHK_EN
    // One-hot class expected for a function code; the all-ones code expects no flag.
    function automatic logic [3:0] expected_flags(input logic [FUN_W-1:0] fun);
        if (fun[3:0] == 4'b1111) return 4'b0000;
        return 4'b0001 << fun[3:2];
    endfunction

    // Flag-check error is registered alongside the captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rsp_err <= 1'b0;
        else if (capture) rsp_err <= (alu_flags != expected_flags(alu_fun));
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a combinational-ALU instance carries the scoreboard
// traffic; a registered-ALU instance covers latency and reset during WAIT.
module tb_alu_cmd_sequencer;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  flags;
        logic        err;
    } rsp_t;

`ifdef ALU_SEQ_FLAGCHK_EN
    localparam bit FLAGCHK = 1'b1;
`else
    localparam bit FLAGCHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_valid1;
    logic        cmd_ready, cmd_ready1;
    logic [15:0] cmd_a, cmd_b;
    logic [3:0]  cmd_fun;
    logic [15:0] alu_a, alu_b, alu_a1, alu_b1;
    logic [3:0]  alu_fun, alu_fun1;
    logic [15:0] alu_out, alu_out1;
    logic [3:0]  alu_flags, alu_flags1;
    logic        rsp_valid, rsp_valid1;
    logic        rsp_ready, rsp_ready1;
    logic [15:0] rsp_data, rsp_data1;
    logic [3:0]  rsp_flags, rsp_flags1;
    logic        rsp_err, rsp_err1;
    logic        busy, busy1;

    logic        force_en;
    logic [3:0]  force_flags;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_rsp    = 0;
    rsp_t sb[$];

    alu_cmd_sequencer #(.DATA_W(16), .FUN_W(4), .DEPTH(4), .ALU_LAT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy)
    );

    alu_cmd_sequencer #(.DATA_W(16), .FUN_W(4), .DEPTH(4), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_fun(alu_fun1),
        .alu_out(alu_out1), .alu_flags(alu_flags1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_data(rsp_data1), .rsp_flags(rsp_flags1), .rsp_err(rsp_err1),
        .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {flags, result}; flags can be forced to provoke a class mismatch.
    function automatic logic [19:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] fun, input logic fen,
                                              input logic [3:0] fflags);
        logic [15:0] r;
        logic [3:0]  f;
        case (fun[3:2])
            2'b00: begin r = fun[0] ? a - b : a + b; f = 4'b0001; end
            2'b01: begin
                case (fun[1:0])
                    2'd0: r = a & b;
                    2'd1: r = a | b;
                    2'd2: r = a ^ b;
                    default: r = ~a;
                endcase
                f = 4'b0010;
            end
            2'b10: begin r = (a < b) ? 16'd1 : 16'd0; f = 4'b0100; end
            default: begin r = a << fun[1:0]; f = (fun == 4'hF) ? 4'b0000 : 4'b1000; end
        endcase
        if (fen) f = fflags;
        return {f, r};
    endfunction

    function automatic logic exp_err(input logic [3:0] fun, input logic [3:0] flags);
        logic [3:0] want;
        want = (fun == 4'hF) ? 4'b0000 : (4'b0001 << fun[1:0] * 0 + fun[3:2]);
        return FLAGCHK && (flags != want);
    endfunction

    always_comb {alu_flags, alu_out} = alu_model(alu_a, alu_b, alu_fun, force_en, force_flags);

    always @(posedge clk) {alu_flags1, alu_out1} <= alu_model(alu_a1, alu_b1, alu_fun1, 1'b0, 4'h0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Response monitor: a handshake seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                n_rsp++;
            end
        end
    end

    // Push one command into the combinational-ALU instance; call at posedge+1.
    task automatic push_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
        int    waited = 0;
        bit    ok     = 1'b0;
        rsp_t  e;
        logic [19:0] m;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_fun   = fun;
        while (!ok && waited < 60) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            else waited++;
        end
        if (!ok) check("push_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (ok) begin
            m       = alu_model(a, b, fun, force_en, force_flags);
            e.data  = m[15:0];
            e.flags = m[19:16];
            e.err   = exp_err(fun, m[19:16]);
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((sb.size() != 0 || busy) && n < 300);
        if (n >= 300) begin
            check("idle_timeout_busy", 32'(busy), 32'd0);
            check("idle_timeout_sb", 32'(sb.size()), 32'd0);
        end
    endtask

    // Counts negedges from posedge+1 until rsp_valid rises (bounded).
    task automatic wait_valid(input bit which, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(which ? rsp_valid1 : rsp_valid) && n < 20);
    endtask

    initial begin
        int          n;
        int          base;
        logic [15:0] held;
        logic        prev_busy;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid1 = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_fun = '0;
        rsp_ready = 1'b0; rsp_ready1 = 1'b1;
        force_en = 1'b0; force_flags = 4'h0;

        // Power-on reset state.
        #12;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_outs", {alu_a, alu_b[11:0], alu_fun}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op, combinational ALU: valid three cycles after the push.
        rsp_ready = 1'b1;
        push_cmd(16'h0003, 16'h0004, 4'h0);
        wait_valid(1'b0, n);
        check("t2_latency", 32'(n), 32'd3);
        check("t2_data", 32'(rsp_data), 32'h0007);
        check("t2_flags", 32'(rsp_flags), 32'h1);
        check("t2_err", 32'(rsp_err), 32'd0);
        wait_idle();

        // Registered ALU: same op, one extra cycle.
        cmd_a = 16'h0003; cmd_b = 16'h0004; cmd_fun = 4'h0;
        cmd_valid1 = 1'b1;
        check("t4_ready", 32'(cmd_ready1), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid1 = 1'b0;
        wait_valid(1'b1, n);
        check("t4_latency", 32'(n), 32'd4);
        check("t4_data", 32'(rsp_data1), 32'h0007);
        check("t4_flags", 32'(rsp_flags1), 32'h1);
        check("t4_err", 32'(rsp_err1), 32'd0);
        @(posedge clk);
        #1;
        check("t4_busy_fall", 32'(busy1), 32'd0);

        // Flag check: logic-class function with arith flags, then with logic flags.
        force_en = 1'b1;
        force_flags = 4'b0001;
        push_cmd(16'h00F0, 16'h0F0F, 4'h5);
        wait_valid(1'b0, n);
        check("t5_err_bad_flags", 32'(rsp_err), 32'(FLAGCHK));
        wait_idle();
        force_flags = 4'b0010;
        push_cmd(16'h00F0, 16'h0F0F, 4'h5);
        wait_valid(1'b0, n);
        check("t5_err_good_flags", 32'(rsp_err), 32'd0);
        wait_idle();
        force_en = 1'b0;

        // Backpressure: one command in HOLD, four buffered, FIFO full.
        rsp_ready = 1'b0;
        base = n_rsp;
        for (int i = 0; i < 5; i++) begin
            push_cmd(16'($urandom), 16'($urandom), 4'(i * 3 + 1));
        end
        @(negedge clk);
        check("t3_full", 32'(cmd_ready), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_valid", 32'(rsp_valid), 32'd1);
        held = rsp_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_data", 32'(rsp_data), 32'(held));
            check("t3_hold_full", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle();
        check("t3_count", 32'(n_rsp - base), 32'd5);

        // Wrap: 3*DEPTH+1 back-to-back commands, then busy falls after the last handshake.
        base = n_rsp;
        for (int i = 0; i < 13; i++) begin
            push_cmd(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
        end
        n = 0;
        prev_busy = 1'b0;
        while (sb.size() != 0 && n < 300) begin
            prev_busy = busy;
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_count", 32'(n_rsp - base), 32'd13);
        check("t6_busy_hold", 32'(prev_busy), 32'd1);
        check("t6_busy_fall", 32'(busy), 32'd0);

        // Reset mid-WAIT on the registered instance, with commands pending in the other.
        rsp_ready = 1'b0;
        cmd_a = 16'h1234; cmd_b = 16'h0001; cmd_fun = 4'h0;
        cmd_valid1 = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid1 = 1'b0;
        push_cmd(16'h0011, 16'h0022, 4'h0);
        push_cmd(16'h0033, 16'h0044, 4'h1);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("t1_ready", {15'd0, cmd_ready, 15'd0, cmd_ready1}, 32'h0001_0001);
        check("t1_busy", {busy, busy1}, 32'd0);
        check("t1_valid", {rsp_valid, rsp_valid1}, 32'd0);
        check("t1_rsp", {rsp_data, rsp_flags, rsp_err, 11'd0}, 32'd0);
        check("t1_rsp1", {rsp_data1, rsp_flags1, rsp_err1, 11'd0}, 32'd0);
        check("t1_alu1", {alu_a1, alu_b1[11:0], alu_fun1}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid || rsp_valid1 || busy || busy1) n++;
        end
        check("t1_no_rsp_after", 32'(n), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
